// File: rtl/spi_boot_image_loader_if.sv
// -----------------------------------------------------------------------------
// spi_boot_image_loader_if
//
// Purpose : groups the byte-stream handshake (from the SPI bootload engine)
//           and the program-RAM write bus of the boot image loader.
//
// Signals (named from the loader's point of view):
//   byte_i       [7:0]            byte read from SPI flash
//   byte_valid_i                  byte_i is valid
//   byte_ready_o                  loader accepts byte_i this cycle
//   wr_en_o                       program-RAM write strobe (one-cycle pulse)
//   wr_addr_o    [ADDR_WIDTH-1:0] program-RAM write address
//   wr_data_o    [17:0]           instruction word to write
//
// Modports:
//   master : upstream byte source / RAM side (drives bytes, observes writes)
//   slave  : the loader itself
// -----------------------------------------------------------------------------
interface spi_boot_image_loader_if #(
    parameter int ADDR_WIDTH = 10
);
    logic [7:0]            byte_i;
    logic                  byte_valid_i;
    logic                  byte_ready_o;
    logic                  wr_en_o;
    logic [ADDR_WIDTH-1:0] wr_addr_o;
    logic [17:0]           wr_data_o;

    modport master (
        output byte_i,
        output byte_valid_i,
        input  byte_ready_o,
        input  wr_en_o,
        input  wr_addr_o,
        input  wr_data_o
    );

    modport slave (
        input  byte_i,
        input  byte_valid_i,
        output byte_ready_o,
        output wr_en_o,
        output wr_addr_o,
        output wr_data_o
    );
endinterface

// File: rtl/spi_boot_image_loader.sv
// -----------------------------------------------------------------------------
// spi_boot_image_loader
//
// Purpose : parses a boot image arriving as a byte stream from SPI flash and
//           writes it into the soft processor's program RAM. Image layout:
//             MAGIC_HI MAGIC_LO LEN_HI LEN_LO {DAT0 DAT1 DAT2} x N CSUM
//           Each 18-bit word is {DAT0[1:0], DAT1, DAT2}. The 8-bit checksum
//           is the modulo-256 sum of the length bytes, all data bytes and the
//           CSUM byte; the image is good when that sum is zero. The processor
//           is released from reset only after a good image.
//
// Ports:
//   clk_i        sole clock
//   rst_b_i      asynchronous active-low reset
//   start_i      one-cycle pulse: begin/restart a load (wins over a byte)
//   bus          slave modport: byte handshake in, program-RAM write bus out
//   cpu_reset_o  holds the soft processor in reset
//   done_o       image loaded and checksum good
//   error_o      0 none, 1 bad magic, 2 bad length, 3 bad checksum
//   state_o      current FSM state encoding (debug observation)
//
// Handshake: a byte transfers on a rising edge where byte_valid_i and
// byte_ready_o are both 1. byte_ready_o depends only on the state (1 in
// MAG_HI..CSUM), so it never combinationally depends on byte_valid_i.
// A source may hold byte_valid_i high across any number of not-ready cycles.
// -----------------------------------------------------------------------------
module spi_boot_image_loader #(
    parameter logic [15:0] MAGIC      = 16'hB007,
    parameter int          ADDR_WIDTH = 10,
    parameter int          MAX_WORDS  = 1024
) (
    input  logic                    clk_i,
    input  logic                    rst_b_i,
    input  logic                    start_i,
    spi_boot_image_loader_if.slave  bus,
    output logic                    cpu_reset_o,
    output logic                    done_o,
    output logic [1:0]              error_o,
    output logic [3:0]              state_o
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        MAG_HI = 4'd1,
        MAG_LO = 4'd2,
        LEN_HI = 4'd3,
        LEN_LO = 4'd4,
        DAT0   = 4'd5,
        DAT1   = 4'd6,
        DAT2   = 4'd7,
        CSUM   = 4'd8,
        DONE   = 4'd9,
        ERR    = 4'd10
    } state_t;

    localparam logic [1:0]  ERR_NONE  = 2'd0;
    localparam logic [1:0]  ERR_MAGIC = 2'd1;
    localparam logic [1:0]  ERR_LEN   = 2'd2;
    localparam logic [1:0]  ERR_CSUM  = 2'd3;
    localparam logic [16:0] MAX_N     = 17'(MAX_WORDS);

    state_t                state_q, state_d;
    logic [15:0]           cnt_q, cnt_d;        // index of the word being assembled
    logic [15:0]           len_q, len_d;        // word count N from the header
    logic [7:0]            len_hi_q, len_hi_d;
    logic [7:0]            sum_q, sum_d;        // running modulo-256 checksum
    logic [1:0]            dat0_q, dat0_d;      // only the low two bits of DAT0 matter
    logic [7:0]            dat1_q, dat1_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [17:0]           wr_data_q, wr_data_d;
    logic                  cpu_reset_q, cpu_reset_d;
    logic                  done_q, done_d;
    logic [1:0]            error_q, error_d;

    logic                  byte_ready;
    logic                  accept;
    logic [15:0]           len_s;
    logic [7:0]            sum_s;

    assign byte_ready = (state_q inside {MAG_HI, MAG_LO, LEN_HI, LEN_LO,
                                         DAT0, DAT1, DAT2, CSUM});
    assign accept     = bus.byte_valid_i && byte_ready;

    always_ff @(posedge clk_i or negedge rst_b_i) begin
        if (!rst_b_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            len_q       <= '0;
            len_hi_q    <= '0;
            sum_q       <= '0;
            dat0_q      <= '0;
            dat1_q      <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            len_hi_q    <= len_hi_d;
            sum_q       <= sum_d;
            dat0_q      <= dat0_d;
            dat1_q      <= dat1_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            cpu_reset_q <= cpu_reset_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        len_hi_d    = len_hi_q;
        sum_d       = sum_q;
        dat0_d      = dat0_q;
        dat1_d      = dat1_q;
        wr_en_d     = 1'b0;               // write strobe is a single-cycle pulse
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        cpu_reset_d = cpu_reset_q;
        done_d      = done_q;
        error_d     = error_q;
        len_s       = {len_hi_q, bus.byte_i};
        sum_s       = sum_q + bus.byte_i;

        if (start_i) begin
            // Restart wins over a byte offered in the same cycle: that byte
            // is dropped, not consumed as MAG_HI.
            state_d     = MAG_HI;
            cnt_d       = '0;
            sum_d       = '0;
            cpu_reset_d = 1'b1;
            done_d      = 1'b0;
            error_d     = ERR_NONE;
        end else if (accept) begin
            unique case (state_q)
                MAG_HI: begin
                    if (bus.byte_i == MAGIC[15:8]) begin
                        state_d = MAG_LO;
                    end else begin
                        state_d = ERR;
                        error_d = ERR_MAGIC;
                    end
                end
                MAG_LO: begin
                    if (bus.byte_i == MAGIC[7:0]) begin
                        state_d = LEN_HI;
                    end else begin
                        state_d = ERR;
                        error_d = ERR_MAGIC;
                    end
                end
                LEN_HI: begin
                    len_hi_d = bus.byte_i;
                    sum_d    = sum_s;
                    state_d  = LEN_LO;
                end
                LEN_LO: begin
                    len_d = len_s;
                    sum_d = sum_s;
                    if (len_s == 16'd0 || {1'b0, len_s} > MAX_N) begin
                        state_d = ERR;
                        error_d = ERR_LEN;
                    end else begin
                        state_d = DAT0;
                    end
                end
                DAT0: begin
                    dat0_d  = bus.byte_i[1:0];
                    sum_d   = sum_s;
                    state_d = DAT1;
                end
                DAT1: begin
                    dat1_d  = bus.byte_i;
                    sum_d   = sum_s;
                    state_d = DAT2;
                end
                DAT2: begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cnt_q[ADDR_WIDTH-1:0];
                    wr_data_d = {dat0_q, dat1_q, bus.byte_i};
                    sum_d     = sum_s;
                    cnt_d     = cnt_q + 16'd1;
                    state_d   = (cnt_q == len_q - 16'd1) ? CSUM : DAT0;
                end
                CSUM: begin
                    sum_d = sum_s;
                    if (sum_s == 8'd0) begin
                        state_d     = DONE;
                        done_d      = 1'b1;
                        cpu_reset_d = 1'b0;
                    end else begin
                        state_d = ERR;
                        error_d = ERR_CSUM;
                    end
                end
                default: ;                 // IDLE/DONE/ERR never accept a byte
            endcase
        end
    end

    assign bus.byte_ready_o = byte_ready;
    assign bus.wr_en_o      = wr_en_q;
    assign bus.wr_addr_o    = wr_addr_q;
    assign bus.wr_data_o    = wr_data_q;
    assign cpu_reset_o      = cpu_reset_q;
    assign done_o           = done_q;
    assign error_o          = error_q;
    assign state_o          = state_q;

endmodule
